// File: rtl/fwd_pkg.sv
// Shared types and defaults for the operand bypass / hazard unit.
package fwd_pkg;

   localparam int unsigned XLEN_DEF    = 32;
   localparam int unsigned NREG_DEF    = 32;
   localparam int unsigned NUM_FWD_DEF = 4;
   localparam int unsigned NUM_SRC_DEF = 2;
   localparam int unsigned RW_DEF      = $clog2(NREG_DEF);
   localparam int unsigned PERF_W      = 32;

   // Producer stage indices, youngest first
   localparam int unsigned STG_EX = 0;
   localparam int unsigned STG_M1 = 1;
   localparam int unsigned STG_M2 = 2;
   localparam int unsigned STG_WB = 3;

   typedef logic [RW_DEF-1:0] reg_idx_t;

   // Per-source resolution: bypass select and the two stall causes
   typedef struct packed {
      logic sel;
      logic load_use;
      logic mc_wait;
   } src_res_t;

endpackage

// File: rtl/fwd_src_select.sv
// Per-source bypass resolution: youngest-first stage search, then scoreboard
// check with same-cycle multi-cycle completion bypass.
module fwd_src_select
   import fwd_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned NUM_FWD = NUM_FWD_DEF,
   parameter int unsigned NREG    = NREG_DEF,
   parameter int unsigned RW      = $clog2(NREG)
) (
   input  logic                    dec_valid_i,
   input  logic [RW-1:0]           rs_i,
   input  logic [NUM_FWD-1:0]      stg_wen_i,
   input  logic [NUM_FWD*RW-1:0]   stg_rd_i,
   input  logic [NUM_FWD-1:0]      stg_rdy_i,
   input  logic [NUM_FWD*XLEN-1:0] stg_data_i,
   input  logic [NREG-1:0]         pending_i,
   input  logic                    mc_done_i,
   input  logic [RW-1:0]           mc_done_rd_i,
   input  logic [XLEN-1:0]         mc_done_data_i,
   output src_res_t                res_o,
   output logic [XLEN-1:0]         data_o
);

   logic            live_c;
   logic            hit_c;
   logic            hit_rdy_c;
   logic [XLEN-1:0] hit_data_c;

   // First matching stage wins; older stages are never consulted
   always_comb begin
      hit_c      = 1'b0;
      hit_rdy_c  = 1'b0;
      hit_data_c = '0;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (!hit_c && stg_wen_i[i] && (stg_rd_i[i*RW +: RW] == rs_i)) begin
            hit_c      = 1'b1;
            hit_rdy_c  = stg_rdy_i[i];
            hit_data_c = stg_data_i[i*XLEN +: XLEN];
         end
      end
   end

   assign live_c = dec_valid_i && (rs_i != '0);

   always_comb begin
      res_o  = '0;
      data_o = '0;
      if (live_c) begin
         if (hit_c) begin
            if (hit_rdy_c) begin
               res_o.sel = 1'b1;
               data_o    = hit_data_c;
            end else begin
               res_o.load_use = 1'b1;
            end
         end else if (pending_i[rs_i]) begin
            if (mc_done_i && (mc_done_rd_i == rs_i)) begin
               res_o.sel = 1'b1;
               data_o    = mc_done_data_i;
            end else begin
               res_o.mc_wait = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass and hazard unit with long-latency writeback scoreboard.
// Optional stall performance counters enabled by FWD_STALL_PERF_EN.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned NUM_SRC = NUM_SRC_DEF,
   parameter int unsigned NUM_FWD = NUM_FWD_DEF,
   parameter int unsigned NREG    = NREG_DEF,
   localparam int unsigned RW     = $clog2(NREG)
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    dec_valid,
   input  logic [NUM_SRC*RW-1:0]   dec_rs,
   input  logic [NUM_FWD-1:0]      stg_wen,
   input  logic [NUM_FWD*RW-1:0]   stg_rd,
   input  logic [NUM_FWD-1:0]      stg_rdy,
   input  logic [NUM_FWD*XLEN-1:0] stg_data,
   input  logic                    mc_issue,
   input  logic [RW-1:0]           mc_rd,
   output logic                    mc_issue_ready,
   input  logic                    mc_done,
   input  logic [RW-1:0]           mc_done_rd,
   input  logic [XLEN-1:0]         mc_done_data,
   output logic [NUM_SRC-1:0]      fwd_sel,
   output logic [NUM_SRC*XLEN-1:0] fwd_data,
   output logic                    stall,
   output logic [NREG-1:0]         pending
`ifdef FWD_STALL_PERF_EN
   ,
   output logic [PERF_W-1:0]       perf_stall_cycles,
   output logic [PERF_W-1:0]       perf_load_use,
   output logic [PERF_W-1:0]       perf_mc_wait
`endif
);

   logic [NREG-1:0]         pending_q, pending_d;
   logic                    issue_ok_c;
   logic [NUM_SRC-1:0]      sel_c, load_use_c, mc_wait_c;
   logic [NUM_SRC*XLEN-1:0] data_c;
   logic                    stall_c;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      src_res_t res;

      fwd_src_select #(
         .XLEN    (XLEN),
         .NUM_FWD (NUM_FWD),
         .NREG    (NREG),
         .RW      (RW)
      ) u_sel (
         .dec_valid_i    (dec_valid),
         .rs_i           (dec_rs[s*RW +: RW]),
         .stg_wen_i      (stg_wen),
         .stg_rd_i       (stg_rd),
         .stg_rdy_i      (stg_rdy),
         .stg_data_i     (stg_data),
         .pending_i      (pending_q),
         .mc_done_i      (mc_done),
         .mc_done_rd_i   (mc_done_rd),
         .mc_done_data_i (mc_done_data),
         .res_o          (res),
         .data_o         (data_c[s*XLEN +: XLEN])
      );

      assign sel_c[s]      = res.sel;
      assign load_use_c[s] = res.load_use;
      assign mc_wait_c[s]  = res.mc_wait;
   end

   assign stall_c = (|load_use_c) || (|mc_wait_c);

   // WAW guard: a pending destination may be reissued only as it completes
   assign issue_ok_c = (mc_rd == '0) || !pending_q[mc_rd] ||
                       (mc_done && (mc_done_rd == mc_rd));

   // Clear on completion first so a same-index issue keeps the bit set
   always_comb begin
      pending_d = pending_q;
      if (mc_done) begin
         pending_d[mc_done_rd] = 1'b0;
      end
      if (mc_issue && issue_ok_c && (mc_rd != '0)) begin
         pending_d[mc_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Reset forces the combinational outputs quiet regardless of inputs
   always_comb begin
      fwd_sel        = '0;
      fwd_data       = '0;
      stall          = 1'b0;
      mc_issue_ready = 1'b1;
      if (nrst) begin
         fwd_sel        = sel_c;
         fwd_data       = data_c;
         stall          = stall_c;
         mc_issue_ready = issue_ok_c;
      end
   end

   assign pending = pending_q;

`ifdef FWD_STALL_PERF_EN
   logic [PERF_W-1:0] stall_cnt_q, lu_cnt_q, mw_cnt_q;

   // Saturating stall counters; a cycle with both causes bumps both
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stall_cnt_q <= '0;
         lu_cnt_q    <= '0;
         mw_cnt_q    <= '0;
      end else begin
         if (stall_c && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
         end
         if ((|load_use_c) && !(&lu_cnt_q)) begin
            lu_cnt_q <= lu_cnt_q + PERF_W'(1);
         end
         if ((|mc_wait_c) && !(&mw_cnt_q)) begin
            mw_cnt_q <= mw_cnt_q + PERF_W'(1);
         end
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_load_use     = lu_cnt_q;
   assign perf_mc_wait      = mw_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized
// traffic against a behavioural model.
module tb_fwd_hazard_unit;

   logic         clk = 1'b0;
   logic         nrst;
   logic         dec_valid;
   logic [9:0]   dec_rs;
   logic [3:0]   stg_wen;
   logic [19:0]  stg_rd;
   logic [3:0]   stg_rdy;
   logic [127:0] stg_data;
   logic         mc_issue;
   logic [4:0]   mc_rd;
   logic         mc_issue_ready;
   logic         mc_done;
   logic [4:0]   mc_done_rd;
   logic [31:0]  mc_done_data;
   logic [1:0]   fwd_sel;
   logic [63:0]  fwd_data;
   logic         stall;
   logic [31:0]  pending;
`ifdef FWD_STALL_PERF_EN
   logic [31:0]  perf_stall_cycles, perf_load_use, perf_mc_wait;
`endif

   int checks = 0;
   int passed = 0;
   bit [31:0] mp;  // model scoreboard

   fwd_hazard_unit dut (
      .clk            (clk),
      .nrst           (nrst),
      .dec_valid      (dec_valid),
      .dec_rs         (dec_rs),
      .stg_wen        (stg_wen),
      .stg_rd         (stg_rd),
      .stg_rdy        (stg_rdy),
      .stg_data       (stg_data),
      .mc_issue       (mc_issue),
      .mc_rd          (mc_rd),
      .mc_issue_ready (mc_issue_ready),
      .mc_done        (mc_done),
      .mc_done_rd     (mc_done_rd),
      .mc_done_data   (mc_done_data),
      .fwd_sel        (fwd_sel),
      .fwd_data       (fwd_data),
      .stall          (stall),
      .pending        (pending)
`ifdef FWD_STALL_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_load_use     (perf_load_use),
      .perf_mc_wait      (perf_mc_wait)
`endif
   );

   always #5 clk = ~clk;

   // Expected {fwd_sel, fwd_data, stall, mc_issue_ready, pending}
   function automatic logic [99:0] model_out();
      logic [1:0]  sel  = '0;
      logic [63:0] data = '0;
      logic        st   = 1'b0;
      logic        rdy;
      if (!nrst) return {2'b00, 64'h0, 1'b0, 1'b1, 32'h0};
      for (int s = 0; s < 2; s++) begin
         int unsigned r = dec_rs[s*5 +: 5];
         int win = -1;
         if (!dec_valid || r == 0) continue;
         for (int i = 0; i < 4; i++)
            if (win < 0 && stg_wen[i] && stg_rd[i*5 +: 5] == r) win = i;
         if (win >= 0) begin
            if (stg_rdy[win]) begin
               sel[s] = 1'b1;
               data[s*32 +: 32] = stg_data[win*32 +: 32];
            end else st = 1'b1;
         end else if (mp[r]) begin
            if (mc_done && mc_done_rd == r) begin
               sel[s] = 1'b1;
               data[s*32 +: 32] = mc_done_data;
            end else st = 1'b1;
         end
      end
      rdy = (mc_rd == 0) || !mp[mc_rd] || (mc_done && mc_done_rd == mc_rd);
      return {sel, data, st, rdy, mp};
   endfunction

   // Advance one clock, applying the scoreboard rules to the model
   task automatic step();
      bit [31:0] nx = mp;
      bit ok = (mc_rd == 0) || !mp[mc_rd] || (mc_done && mc_done_rd == mc_rd);
      if (nrst) begin
         if (mc_done) nx[mc_done_rd] = 1'b0;
         if (mc_issue && ok && mc_rd != 0) nx[mc_rd] = 1'b1;
      end
      @(posedge clk);
      mp = nx;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      dec_valid = 0; dec_rs = '0; stg_wen = '0; stg_rd = '0; stg_rdy = '0;
      stg_data = '0; mc_issue = 0; mc_rd = '0; mc_done = 0; mc_done_rd = '0;
      mc_done_data = '0;
   endtask

   task automatic set_stg(input int i, input bit wen, input logic [4:0] rd,
                          input bit rdy, input logic [31:0] d);
      stg_wen[i] = wen; stg_rd[i*5 +: 5] = rd; stg_rdy[i] = rdy;
      stg_data[i*32 +: 32] = d;
   endtask

   task automatic test_reset();
      clear_inputs();
      nrst = 0;
      dec_valid = 1; dec_rs = {5'd0, 5'd5};
      set_stg(0, 1, 5'd5, 1, 32'h11);
      set_stg(1, 1, 5'd0, 0, 32'h0);
      mc_rd = 5'd4;
      #1;
      checks++;
      if ({fwd_sel, fwd_data, stall, pending} !== '0 || mc_issue_ready !== 1'b1)
         $display("FAIL reset_outputs got sel=%b data=%h stall=%b rdy=%b pend=%h want zeros rdy=1",
                  fwd_sel, fwd_data, stall, mc_issue_ready, pending);
      else passed++;
      @(negedge clk);
      clear_inputs();
      nrst = 1;
      mp = '0;
      @(negedge clk);
   endtask

   task automatic test_stage_priority();
      clear_inputs();
      dec_valid = 1; dec_rs = {5'd0, 5'd5};
      set_stg(0, 1, 5'd5, 1, 32'h11);
      set_stg(2, 1, 5'd5, 1, 32'h22);
      #1;
      checks++;
      if (fwd_sel !== 2'b01 || fwd_data[31:0] !== 32'h11 || stall !== 1'b0)
         $display("FAIL prio_youngest got sel=%b d0=%h stall=%b want sel=01 d0=11 stall=0",
                  fwd_sel, fwd_data[31:0], stall);
      else passed++;
      step();
   endtask

   task automatic test_load_use();
      clear_inputs();
      dec_valid = 1; dec_rs = {5'd7, 5'd0};
      set_stg(0, 1, 5'd7, 0, 32'h55);
      set_stg(1, 1, 5'd7, 1, 32'h66);
      #1;
      checks++;
      if (stall !== 1'b1 || fwd_sel[1] !== 1'b0 || fwd_data[63:32] !== 32'h0)
         $display("FAIL load_use_stall got stall=%b sel1=%b d1=%h want stall=1 sel1=0 d1=0",
                  stall, fwd_sel[1], fwd_data[63:32]);
      else passed++;
      step();
      set_stg(0, 0, 5'd0, 0, 32'h0);
      set_stg(1, 1, 5'd7, 1, 32'hABCD);
      #1;
      checks++;
      if (stall !== 1'b0 || fwd_sel[1] !== 1'b1 || fwd_data[63:32] !== 32'hABCD)
         $display("FAIL load_use_release got stall=%b sel1=%b d1=%h want stall=0 sel1=1 d1=abcd",
                  stall, fwd_sel[1], fwd_data[63:32]);
      else passed++;
      step();
   endtask

   task automatic test_scoreboard();
      clear_inputs();
      mc_issue = 1; mc_rd = 5'd9;
      step();
      clear_inputs();
      #1;
      checks++;
      if (pending !== 32'h200)
         $display("FAIL sb_issue got pend=%h want 00000200", pending);
      else passed++;
      dec_valid = 1; dec_rs = {5'd0, 5'd9};
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (stall !== 1'b1 || fwd_sel !== 2'b00)
            $display("FAIL sb_wait%0d got stall=%b sel=%b want stall=1 sel=00", c, stall, fwd_sel);
         else passed++;
         step();
      end
      mc_done = 1; mc_done_rd = 5'd9; mc_done_data = 32'h1234;
      #1;
      checks++;
      if (stall !== 1'b0 || fwd_sel !== 2'b01 || fwd_data[31:0] !== 32'h1234)
         $display("FAIL sb_done_bypass got stall=%b sel=%b d0=%h want stall=0 sel=01 d0=1234",
                  stall, fwd_sel, fwd_data[31:0]);
      else passed++;
      step();
      mc_done = 0;
      #1;
      checks++;
      if (pending !== 32'h0 || stall !== 1'b0 || fwd_sel !== 2'b00)
         $display("FAIL sb_cleared got pend=%h stall=%b sel=%b want 0/0/00", pending, stall, fwd_sel);
      else passed++;
      step();
   endtask

   task automatic test_waw();
      clear_inputs();
      mc_issue = 1; mc_rd = 5'd3;
      step();
      #1;
      checks++;
      if (mc_issue_ready !== 1'b0 || pending !== 32'h8)
         $display("FAIL waw_block got rdy=%b pend=%h want rdy=0 pend=00000008", mc_issue_ready, pending);
      else passed++;
      step();
      #1;
      checks++;
      if (pending !== 32'h8)
         $display("FAIL waw_ignored got pend=%h want 00000008", pending);
      else passed++;
      mc_done = 1; mc_done_rd = 5'd3;
      #1;
      checks++;
      if (mc_issue_ready !== 1'b1)
         $display("FAIL waw_done_ready got rdy=%b want 1", mc_issue_ready);
      else passed++;
      step();
      mc_issue = 0;
      #1;
      checks++;
      if (pending !== 32'h8)
         $display("FAIL waw_set_wins got pend=%h want 00000008", pending);
      else passed++;
      step();
      mc_done = 0;
      step();
      #1;
      checks++;
      if (pending !== 32'h0)
         $display("FAIL waw_drain got pend=%h want 0", pending);
      else passed++;
   endtask

   task automatic test_zero_and_invalid();
      clear_inputs();
      dec_valid = 1; dec_rs = '0;
      set_stg(0, 1, 5'd0, 0, 32'hDEAD);
      set_stg(1, 1, 5'd0, 1, 32'hBEEF);
      #1;
      checks++;
      if (fwd_sel !== 2'b00 || stall !== 1'b0 || fwd_data !== 64'h0)
         $display("FAIL x0_source got sel=%b stall=%b data=%h want 00/0/0", fwd_sel, stall, fwd_data);
      else passed++;
      dec_valid = 0; dec_rs = {5'd6, 5'd5};
      set_stg(0, 1, 5'd5, 0, 32'h1);
      set_stg(1, 1, 5'd6, 1, 32'h2);
      #1;
      checks++;
      if (fwd_sel !== 2'b00 || stall !== 1'b0 || fwd_data !== 64'h0)
         $display("FAIL dec_invalid got sel=%b stall=%b data=%h want 00/0/0", fwd_sel, stall, fwd_data);
      else passed++;
      clear_inputs();
      mc_issue = 1; mc_rd = 5'd0;
      step();
      mc_issue = 0;
      #1;
      checks++;
      if (pending !== 32'h0)
         $display("FAIL issue_x0 got pend=%h want 0", pending);
      else passed++;
   endtask

   task automatic test_async_reset();
      clear_inputs();
      mc_issue = 1; mc_rd = 5'd6;
      step();
      mc_rd = 5'd9;
      step();
      clear_inputs();
      dec_valid = 1; dec_rs = {5'd9, 5'd6};
      #1;
      checks++;
      if (pending !== 32'h240 || stall !== 1'b1)
         $display("FAIL arst_setup got pend=%h stall=%b want 00000240/1", pending, stall);
      else passed++;
      #1 nrst = 0;
      #1;
      checks++;
      if (pending !== 32'h0 || stall !== 1'b0 || fwd_sel !== 2'b00 || mc_issue_ready !== 1'b1)
         $display("FAIL arst_immediate got pend=%h stall=%b sel=%b rdy=%b want 0/0/00/1",
                  pending, stall, fwd_sel, mc_issue_ready);
      else passed++;
      mp = '0;
      @(negedge clk);
      clear_inputs();
      nrst = 1;
      @(negedge clk);
   endtask

`ifdef FWD_STALL_PERF_EN
   task automatic test_perf();
      clear_inputs();
      #1;
      checks++;
      if (perf_stall_cycles !== 0 || perf_load_use !== 0 || perf_mc_wait !== 0)
         $display("FAIL perf_after_reset got %0d/%0d/%0d want 0/0/0",
                  perf_stall_cycles, perf_load_use, perf_mc_wait);
      else passed++;
      dec_valid = 1; dec_rs = {5'd0, 5'd4};
      set_stg(0, 1, 5'd4, 0, 32'h0);
      for (int c = 0; c < 3; c++) step();
      clear_inputs();
      step();
      checks++;
      if (perf_stall_cycles !== 3 || perf_load_use !== 3 || perf_mc_wait !== 0)
         $display("FAIL perf_count got %0d/%0d/%0d want 3/3/0",
                  perf_stall_cycles, perf_load_use, perf_mc_wait);
      else passed++;
   endtask
`endif

   task automatic test_random();
      logic [99:0] exp, got;
      for (int n = 0; n < 400; n++) begin
         dec_valid = ($urandom_range(0, 3) != 0);
         for (int s = 0; s < 2; s++) dec_rs[s*5 +: 5] = 5'($urandom_range(0, 7));
         for (int i = 0; i < 4; i++)
            set_stg(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0), $urandom);
         mc_issue     = ($urandom_range(0, 2) == 0);
         mc_rd        = 5'($urandom_range(0, 7));
         mc_done      = ($urandom_range(0, 2) == 0);
         mc_done_rd   = 5'($urandom_range(0, 7));
         mc_done_data = $urandom;
         #1;
         exp = model_out();
         got = {fwd_sel, fwd_data, stall, mc_issue_ready, pending};
         checks++;
         if (got !== exp)
            $display("FAIL random_%0d got %h want %h", n, got, exp);
         else passed++;
         step();
      end
   endtask

   initial begin
      mp = '0;
      clear_inputs();
      nrst = 0;
      @(negedge clk);
      test_reset();
      test_stage_priority();
      test_load_use();
      test_scoreboard();
      test_waw();
      test_zero_and_invalid();
      test_async_reset();
`ifdef FWD_STALL_PERF_EN
      test_perf();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
